// File: rtl/des_pkg.sv
// Shared DES round-controller types: FSM state encoding, round count, key schedules.
// The schedule tables are indexed by 0-based round number.
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam logic KEY_DIR_LEFT  = 1'b0;
    localparam logic KEY_DIR_RIGHT = 1'b1;

    localparam logic [1:0] ENC_SHIFT [DES_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Round 0 of decryption reuses the PC-1 key as-is; that key equals K16.
    localparam logic [1:0] DEC_SHIFT [DES_ROUNDS] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_round_ctrl_if.sv
// Handshake and datapath-strobe bundle between the DES round controller and its datapath/host.
// The abort input exists only when DES_ROUND_CTRL_ABORT_EN is defined.
interface des_round_ctrl_if;
    logic       in_valid;
    logic       in_decrypt;
    logic       in_ready;
    logic       ip_load;
    logic       round_en;
    logic [3:0] round_idx;
    logic [1:0] key_shift;
    logic       key_dir;
    logic       fp_load;
    logic       out_valid;
    logic       out_ready;
`ifdef DES_ROUND_CTRL_ABORT_EN
    logic       abort;
`endif

    modport master (
        output
`ifdef DES_ROUND_CTRL_ABORT_EN
               abort,
`endif
               in_valid, in_decrypt, out_ready,
        input  in_ready, ip_load, round_en, round_idx, key_shift, key_dir, fp_load, out_valid
    );

    modport slave (
        input
`ifdef DES_ROUND_CTRL_ABORT_EN
               abort,
`endif
               in_valid, in_decrypt, out_ready,
        output in_ready, ip_load, round_en, round_idx, key_shift, key_dir, fp_load, out_valid
    );
endinterface

// File: rtl/des_key_sched_lut.sv
// Purpose: maps round number and mode to C/D rotate amount and direction.
// Latency: combinational, zero cycles.
// Backpressure: none; key_shift forced to 0 whenever active is low.
module des_key_sched_lut
    import des_pkg::*;
(
    input  logic [3:0] round_idx,
    input  logic       mode,
    input  logic       active,
    output logic [1:0] key_shift,
    output logic       key_dir
);

    always_comb begin
        key_dir   = mode ? KEY_DIR_RIGHT : KEY_DIR_LEFT;
        key_shift = 2'd0;
        if (active) begin
            key_shift = mode ? DEC_SHIFT[round_idx] : ENC_SHIFT[round_idx];
        end
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Purpose: sequences IP load, NUM_ROUNDS Feistel rounds and FP capture for one DES block (abort via DES_ROUND_CTRL_ABORT_EN).
// Latency: ip_load 1 cycle after accept, out_valid NUM_ROUNDS+3 cycles after accept.
// Backpressure: result held in DONE until out_ready; a new block may be accepted in that same cycle.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_ROUNDS
) (
    input  logic           clk,
    input  logic           rst_n,
    des_round_ctrl_if.slave bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t     state;
    logic       mode;
    logic [3:0] round_cnt;
    logic       ip_load;
    logic       round_en;
    logic       fp_load;
    logic       out_valid;
    logic       accept;
    logic       abort_hit;

`ifdef DES_ROUND_CTRL_ABORT_EN
    assign abort_hit = bus.abort && (state != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign bus.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign accept       = bus.in_ready && bus.in_valid && !abort_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode      <= 1'b0;
            round_cnt <= 4'd0;
            ip_load   <= 1'b0;
            round_en  <= 1'b0;
            fp_load   <= 1'b0;
            out_valid <= 1'b0;
        end else if (abort_hit) begin
            state     <= ST_IDLE;
            round_cnt <= 4'd0;
            ip_load   <= 1'b0;
            round_en  <= 1'b0;
            fp_load   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_LOAD;
                        mode    <= bus.in_decrypt;
                        ip_load <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state     <= ST_ROUND;
                    ip_load   <= 1'b0;
                    round_en  <= 1'b1;
                    round_cnt <= 4'd0;
                end
                ST_ROUND: begin
                    if (round_cnt == LAST_ROUND) begin
                        state     <= ST_FINAL;
                        round_en  <= 1'b0;
                        fp_load   <= 1'b1;
                        round_cnt <= 4'd0;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                ST_FINAL: begin
                    state     <= ST_DONE;
                    fp_load   <= 1'b0;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    // Draining the result and accepting the next block share one cycle.
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            state   <= ST_LOAD;
                            mode    <= bus.in_decrypt;
                            ip_load <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    round_cnt <= 4'd0;
                    ip_load   <= 1'b0;
                    round_en  <= 1'b0;
                    fp_load   <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ip_load   = ip_load;
    assign bus.round_en  = round_en;
    assign bus.round_idx = round_cnt;
    assign bus.fp_load   = fp_load;
    assign bus.out_valid = out_valid;

    des_key_sched_lut u_key_sched (
        .round_idx (round_cnt),
        .mode      (mode),
        .active    (round_en),
        .key_shift (bus.key_shift),
        .key_dir   (bus.key_dir)
    );

endmodule
